fetch_instr_queue: RTL and testbench

//  Instruction buffer between the fetch stage and the decode stage (decoder + immediate generator).

---
 rtl/fetch_instr_queue_if.sv | 32 +++
 rtl/fetch_instr_queue.sv | 82 ++++++++
 tb/tb_fetch_instr_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_instr_queue_if.sv
// Fetch-to-decode instruction queue bus: the push side faces fetch, the pop side faces decode.
// The slave modport is the queue itself. The master modport is the fetch/decode pair that drives it.
interface fetch_instr_queue_if #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush_i;
  logic              push_valid_i;
  logic              push_ready_o;
  logic [PC_W-1:0]   push_pc_i;
  logic [INST_W-1:0] push_instr_i;
  logic              push_ex_i;
  logic              pop_valid_o;
  logic              pop_ready_i;
  logic [PC_W-1:0]   pop_pc_o;
  logic [INST_W-1:0] pop_instr_o;
  logic              pop_ex_o;
  logic [CNT_W-1:0]  count_o;

  modport slave (
    input  flush_i, push_valid_i, push_pc_i, push_instr_i, push_ex_i, pop_ready_i,
    output push_ready_o, pop_valid_o, pop_pc_o, pop_instr_o, pop_ex_o, count_o
  );

  modport master (
    output flush_i, push_valid_i, push_pc_i, push_instr_i, push_ex_i, pop_ready_i,
    input  push_ready_o, pop_valid_o, pop_pc_o, pop_instr_o, pop_ex_o, count_o
  );
endinterface

// File: rtl/fetch_instr_queue.sv
// First-word fall-through instruction queue between fetch and decode.
// Each entry holds a PC, an instruction word and a fetch-exception flag.
module fetch_instr_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  fetch_instr_queue_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PC_W-1:0]   ent_pc_q    [DEPTH];
  logic [INST_W-1:0] ent_instr_q [DEPTH];
  logic              ent_ex_q    [DEPTH];

  logic full, empty, push, pop, wr_en;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = bus.push_valid_i & ~full;
  assign pop   = bus.pop_ready_i & ~empty;
  // A push that coincides with a flush is dropped, so it must not touch storage either.
  assign wr_en = push & ~bus.flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (bus.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; valid data is tracked only by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      ent_pc_q[wr_ptr_q]    <= bus.push_pc_i;
      ent_instr_q[wr_ptr_q] <= bus.push_instr_i;
      ent_ex_q[wr_ptr_q]    <= bus.push_ex_i;
    end
  end

  always_comb begin
    bus.push_ready_o = ~full;
    bus.pop_valid_o  = ~empty;
    bus.count_o      = cnt_q;
    bus.pop_pc_o     = '0;
    bus.pop_instr_o  = NOP;
    bus.pop_ex_o     = 1'b0;
    if (!empty) begin
      bus.pop_pc_o    = ent_pc_q[rd_ptr_q];
      bus.pop_instr_o = ent_instr_q[rd_ptr_q];
      bus.pop_ex_o    = ent_ex_q[rd_ptr_q];
    end
  end
endmodule

// File: tb/tb_fetch_instr_queue.sv
// Bench for fetch_instr_queue: table of per-cycle stimulus with expected handshake/count,
// plus a scoreboard queue of pushed entries that the head output is compared against.
module tb_fetch_instr_queue;
  localparam int DEPTH  = 4;
  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        flush;
    logic        push_valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        ex;
    logic        pop_ready;
    int          exp_count;
    logic        exp_push_ready;
    logic        exp_pop_valid;
  } row_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        ex;
  } ent_t;

  logic clk;
  logic rstn;
  int   total;
  int   bad;
  row_t vec[$];
  ent_t sb[$];

  fetch_instr_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) qif ();

  fetch_instr_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (qif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [63:0] pc);
    if (pc == 64'h1000) return 32'h0050_0093;
    return {pc[11:0], 20'h00093};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic fl, input logic pv, input logic [63:0] pc, input logic ex,
                     input logic pr, input int ec, input logic epr, input logic epv);
    row_t r;
    r.flush = fl; r.push_valid = pv; r.pc = pc; r.instr = mk_instr(pc); r.ex = ex;
    r.pop_ready = pr; r.exp_count = ec; r.exp_push_ready = epr; r.exp_pop_valid = epv;
    vec.push_back(r);
  endtask

  task automatic check_head();
    if (sb.size() == 0) begin
      check("empty_pc", qif.pop_pc_o, 64'h0);
      check("empty_instr", 64'(qif.pop_instr_o), 64'(NOP));
      check("empty_ex", 64'(qif.pop_ex_o), 64'h0);
    end else begin
      check("head_pc", qif.pop_pc_o, sb[0].pc);
      check("head_instr", 64'(qif.pop_instr_o), 64'(sb[0].instr));
      check("head_ex", 64'(qif.pop_ex_o), 64'(sb[0].ex));
    end
  endtask

  // Called at posedge+1; samples at the following negedge and returns at the next posedge+1.
  task automatic apply(input row_t r, input int idx);
    logic push_fire, pop_fire;
    qif.flush_i      = r.flush;
    qif.push_valid_i = r.push_valid;
    qif.push_pc_i    = r.pc;
    qif.push_instr_i = r.instr;
    qif.push_ex_i    = r.ex;
    qif.pop_ready_i  = r.pop_ready;
    @(negedge clk);
    check("count", 64'(qif.count_o), 64'(r.exp_count));
    check("push_ready", 64'(qif.push_ready_o), 64'(r.exp_push_ready));
    check("pop_valid", 64'(qif.pop_valid_o), 64'(r.exp_pop_valid));
    check_head();
    push_fire = r.push_valid && r.exp_push_ready;
    pop_fire  = r.pop_ready && r.exp_pop_valid;
    $display("txn %0d flush=%0b push=%0b pc=%0h pop=%0b head_pc=%0h count=%0d",
             idx, r.flush, push_fire, r.pc, pop_fire, qif.pop_pc_o, qif.count_o);
    if (r.flush) begin
      sb.delete();
    end else begin
      if (pop_fire && sb.size() > 0) void'(sb.pop_front());
      if (push_fire) sb.push_back('{pc: r.pc, instr: r.instr, ex: r.ex});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    qif.flush_i      = 1'b0;
    qif.push_valid_i = 1'b0;
    qif.push_pc_i    = '0;
    qif.push_instr_i = '0;
    qif.push_ex_i    = 1'b0;
    qif.pop_ready_i  = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    @(negedge clk);
    check("rst_pop_valid", 64'(qif.pop_valid_o), 64'h0);
    check("rst_push_ready", 64'(qif.push_ready_o), 64'h1);
    check("rst_count", 64'(qif.count_o), 64'h0);
    check("rst_instr", 64'(qif.pop_instr_o), 64'(NOP));
    check("rst_pc", qif.pop_pc_o, 64'h0);
    @(posedge clk);
    #1;

    // Single push, visible one cycle later, then consumed
    add(0, 1, 64'h1000, 0, 0, 0, 1, 0);
    add(0, 0, 64'h0,    0, 0, 1, 1, 1);
    add(0, 0, 64'h0,    0, 1, 1, 1, 1);
    // Fill past capacity; fifth entry held until a slot frees
    for (int i = 0; i < 5; i++)
      add(0, 1, 64'(i * 4), (i == 2), 0, (i < 4) ? i : 4, (i < 4), (i > 0));
    add(0, 1, 64'h10, 0, 1, 4, 0, 1);
    add(0, 1, 64'h10, 0, 1, 3, 1, 1);
    add(0, 0, 64'h0,  0, 1, 3, 1, 1);
    add(0, 0, 64'h0,  0, 1, 2, 1, 1);
    // Steady push+pop at occupancy 2 across pointer wrap
    add(0, 1, 64'h20, 0, 0, 1, 1, 1);
    for (int k = 0; k < 10; k++)
      add(0, 1, 64'(32'h24 + k * 4), k[0], 1, 2, 1, 1);
    // Fill, then flush together with push and pop
    add(0, 1, 64'h100,  0, 0, 2, 1, 1);
    add(0, 1, 64'h104,  1, 0, 3, 1, 1);
    add(1, 1, 64'h108,  0, 1, 4, 0, 1);
    add(0, 0, 64'h0,    0, 0, 0, 1, 0);
    add(0, 1, 64'h2000, 0, 0, 0, 1, 0);
    add(0, 0, 64'h0,    0, 0, 1, 1, 1);
    add(0, 0, 64'h0,    0, 1, 1, 1, 1);
    add(0, 0, 64'h0,    0, 0, 0, 1, 0);
    // Entries with exception flag ahead of an asynchronous reset
    add(0, 1, 64'h3000, 1, 0, 0, 1, 0);
    add(0, 1, 64'h3004, 0, 0, 1, 1, 1);
    add(0, 0, 64'h0,    0, 0, 2, 1, 1);

    foreach (vec[i]) apply(vec[i], i);

    // Asynchronous reset mid-stream must drop entries without waiting for a clock edge
    #2;
    rstn = 1'b0;
    #1;
    check("arst_pop_valid", 64'(qif.pop_valid_o), 64'h0);
    check("arst_count", 64'(qif.count_o), 64'h0);
    check("arst_push_ready", 64'(qif.push_ready_o), 64'h1);
    check("arst_instr", 64'(qif.pop_instr_o), 64'(NOP));
    check("arst_ex", 64'(qif.pop_ex_o), 64'h0);
    $display("txn reset asserted mid-stream count=%0d", qif.count_o);
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    vec.delete();
    add(0, 0, 64'h0,    0, 0, 0, 1, 0);
    add(0, 1, 64'h3100, 1, 0, 0, 1, 0);
    add(0, 0, 64'h0,    0, 1, 1, 1, 1);
    add(0, 0, 64'h0,    0, 0, 0, 1, 0);
    foreach (vec[i]) apply(vec[i], 100 + i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
